// File: rtl/band_bar_scaler.sv
// Log-scaled bar height per band, with peak hold, frame-rate peak decay and a registered read port.
// Each accepted average is scanned one bit per cycle to find its bit length, which sets the height.
module band_bar_scaler #(
  parameter int unsigned NUM_BANDS    = 8,
  parameter int unsigned IN_W         = 64,
  parameter int unsigned PRE_SHIFT    = 0,
  parameter int unsigned HEIGHT_STEP  = 4,
  parameter int unsigned MAX_H        = 120,
  parameter int unsigned H_W          = 7,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         avg_valid,
  output logic                         avg_ready,
  input  logic [$clog2(NUM_BANDS)-1:0] avg_band,
  input  logic [IN_W-1:0]              avg_in,
  input  logic                         frame_tick,
  input  logic [$clog2(NUM_BANDS)-1:0] rd_band,
  output logic [H_W-1:0]               rd_bar,
  output logic [H_W-1:0]               rd_peak,
  output logic                         update_done
);

  localparam int unsigned BW = $clog2(NUM_BANDS);
  localparam int unsigned CW = $clog2(IN_W + 1);
  localparam int unsigned DW = $clog2(DECAY_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StScan, StUpdate} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] work_q, work_d;
  logic [BW-1:0]   band_q, band_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            decay_strobe;
  logic [15:0]     h_wide;
  logic [H_W-1:0]  h;
  logic [H_W-1:0]  bar_q  [NUM_BANDS];
  logic [H_W-1:0]  bar_d  [NUM_BANDS];
  logic [H_W-1:0]  peak_q [NUM_BANDS];
  logic [H_W-1:0]  peak_d [NUM_BANDS];
  logic [H_W-1:0]  rd_bar_q, rd_peak_q;
  logic            update_done_q;

  assign avg_ready   = (state_q == StIdle);
  assign rd_bar      = rd_bar_q;
  assign rd_peak     = rd_peak_q;
  assign update_done = update_done_q;

  // Conversion FSM: accept, count bit length by shifting, then commit the height.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (avg_valid) begin
          work_d  = avg_in >> PRE_SHIFT;
          band_d  = avg_band;
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (work_q == '0) begin
          state_d = StUpdate;
        end else begin
          work_d = work_q >> 1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Height from bit length; wide product so large counts clamp instead of wrapping.
  always_comb begin
    h_wide = 16'(cnt_q) * 16'(HEIGHT_STEP);
    h      = (h_wide > 16'(MAX_H)) ? H_W'(MAX_H) : h_wide[H_W-1:0];
  end

  // Frame counter; strobe fires on the tick that completes a decay period.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    decay_strobe = 1'b0;
    if (frame_tick) begin
      if (tick_cnt_q == DW'(DECAY_FRAMES - 1)) begin
        tick_cnt_d   = '0;
        decay_strobe = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Bar/peak next state: decay above bar, then the update overrides its own band.
  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      bar_d[b]  = bar_q[b];
      peak_d[b] = peak_q[b];
      if (decay_strobe && (peak_q[b] > bar_q[b])) begin
        peak_d[b] = peak_q[b] - 1'b1;
      end
    end
    if (state_q == StUpdate) begin
      bar_d[band_q]  = h;
      peak_d[band_q] = (peak_q[band_q] > h) ? peak_q[band_q] : h;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      work_q        <= '0;
      band_q        <= '0;
      cnt_q         <= '0;
      tick_cnt_q    <= '0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      band_q        <= band_d;
      cnt_q         <= cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      update_done_q <= (state_q == StUpdate);
    end
  end

  // Per-band bar and peak storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        bar_q[b]  <= '0;
        peak_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        bar_q[b]  <= bar_d[b];
        peak_q[b] <= peak_d[b];
      end
    end
  end

  // Registered read port; a same-edge update is seen on the following read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_bar_q  <= '0;
      rd_peak_q <= '0;
    end else begin
      rd_bar_q  <= bar_q[rd_band];
      rd_peak_q <= peak_q[rd_band];
    end
  end

endmodule
